// File: rtl/div_24bit_seq.sv
// ----------------------------------------------------------------------------
// div_24bit_seq
//
// Sequential unsigned restoring divider. It accepts one request at a time
// through a valid/ready handshake and spends one cycle per quotient bit. It
// then holds the quotient and remainder until the consumer takes them. A zero
// divisor skips the iterations and returns an all-ones quotient, with the
// dividend as the remainder and the div-by-zero flag set.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_in_valid     request present
//   o_in_ready     divider idle and able to accept a request
//   i_dividend     unsigned dividend, sampled on accept
//   i_divisor      unsigned divisor, sampled on accept
//   o_out_valid    result available
//   i_out_ready    consumer takes the result
//   o_quotient     unsigned quotient
//   o_remainder    unsigned remainder
//   o_div_by_zero  result came from a zero divisor
// ----------------------------------------------------------------------------
module div_24bit_seq #(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;        // quotient shift register
    logic [WIDTH:0]   r_q, r_d;        // partial remainder, one guard bit
    logic [WIDTH-1:0] div_q, div_d;    // latched divisor
    logic [CNT_W-1:0] cnt_q, cnt_d;    // iteration counter
    logic             dbz_q, dbz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [2*WIDTH:0] step_s;          // {next remainder, next quotient}

    // One restoring iteration: shift the quotient MSB into the remainder, then
    // trial-subtract the divisor. The quotient bit is set when no borrow occurs.
    function automatic logic [2*WIDTH:0] div_step(
        input logic [WIDTH:0]   rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0]   r_sh;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] q_sh;
        r_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
        q_sh = {quo[WIDTH-2:0], 1'b0};
        diff = r_sh - {1'b0, dvs};
        if (diff[WIDTH] == 1'b0) begin
            r_sh    = diff;
            q_sh[0] = 1'b1;
        end else begin
            q_sh[0] = 1'b0;
        end
        return {r_sh, q_sh};
    endfunction

    // Next-state and datapath logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        step_s  = div_step(r_q, q_q, div_q);

        case (state_q)
            ST_IDLE: begin
                if (i_in_valid) begin
                    div_d = i_divisor;
                    cnt_d = {CNT_W{1'b0}};
                    if (i_divisor == {WIDTH{1'b0}}) begin
                        // Zero divisor: the final result is loaded directly,
                        // so the iteration phase is skipped.
                        q_d     = {WIDTH{1'b1}};
                        r_d     = {1'b0, i_dividend};
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        q_d     = i_dividend;
                        r_d     = {(WIDTH + 1){1'b0}};
                        dbz_d   = 1'b0;
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                r_d   = step_s[2*WIDTH:WIDTH];
                q_d   = step_s[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered, so they are derived from the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            q_q         <= {WIDTH{1'b0}};
            r_q         <= {(WIDTH + 1){1'b0}};
            div_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_in_ready    = in_ready_q;
    assign o_out_valid   = out_valid_q;
    assign o_quotient    = q_q;
    assign o_remainder   = r_q[WIDTH-1:0];
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_24bit_seq.sv
// ----------------------------------------------------------------------------
// tb_div_24bit_seq
//
// Directed-vector bench for div_24bit_seq. It runs the basic, extreme,
// divide-by-zero, backpressure and mid-operation reset cases, followed by a
// short run of random operand pairs that are checked against the / and %
// operators.
// ----------------------------------------------------------------------------
module tb_div_24bit_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [23:0] i_dividend = 24'd0;
    logic [23:0] i_divisor = 24'd0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [23:0] o_quotient;
    logic [23:0] o_remainder;
    logic        o_div_by_zero;

    int chk_cnt = 0;
    int err_cnt = 0;

    div_24bit_seq #(.WIDTH(24)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    // Count one comparison and report it if it fails.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for the divider to become ready, then present one request for one edge.
    task automatic accept(input logic [23:0] a, input logic [23:0] b);
        int n = 0;
        while (!o_in_ready && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        check_eq("accept_ready", {31'd0, o_in_ready}, 32'd1);
        i_in_valid = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        i_dividend = 24'($urandom);
        i_divisor  = 24'($urandom);
    endtask

    // Count the cycles from accept to o_out_valid, then check the result.
    task automatic wait_done(input string tag, input int exp_lat, input logic [23:0] eq,
                             input logic [23:0] er, input logic edbz);
        int lat = 0;
        do begin
            @(posedge i_clk); #1;
            lat++;
        end while (!o_out_valid && lat < 100);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_q"}, {8'd0, o_quotient}, {8'd0, eq});
        check_eq({tag, "_r"}, {8'd0, o_remainder}, {8'd0, er});
        check_eq({tag, "_dbz"}, {31'd0, o_div_by_zero}, {31'd0, edbz});
        check_eq({tag, "_rdy"}, {31'd0, o_in_ready}, 32'd0);
    endtask

    // Complete the output handshake and check that the divider returns to idle.
    task automatic release_out(input string tag);
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
        check_eq({tag, "_vld_off"}, {31'd0, o_out_valid}, 32'd0);
        check_eq({tag, "_rdy_on"}, {31'd0, o_in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic [23:0] eq, input logic [23:0] er);
        accept(a, b);
        if (b == 24'd0) begin
            wait_done(tag, 1, eq, er, 1'b1);
        end else begin
            wait_done(tag, 24, eq, er, 1'b0);
        end
        release_out(tag);
    endtask

    initial begin
        int quiet;
        logic [23:0] ra, rb, rq, rr;

        // Reset state.
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check_eq("rst_rdy", {31'd0, o_in_ready}, 32'd1);
        check_eq("rst_vld", {31'd0, o_out_valid}, 32'd0);
        check_eq("rst_q", {8'd0, o_quotient}, 32'd0);
        check_eq("rst_r", {8'd0, o_remainder}, 32'd0);
        check_eq("rst_dbz", {31'd0, o_div_by_zero}, 32'd0);

        // Basic and extreme vectors.
        run_op("basic", 24'd100, 24'd7, 24'd14, 24'd2);
        run_op("max_by_1", 24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0);
        run_op("max_by_max", 24'hFFFFFF, 24'hFFFFFF, 24'd1, 24'd0);
        run_op("small", 24'd3, 24'd10, 24'd0, 24'd3);
        run_op("div0", 24'd5, 24'd0, 24'hFFFFFF, 24'd5);
        run_op("odd", 24'd1234567, 24'd89, 24'd13871, 24'd48);

        // Backpressure: hold the result for 5 cycles while another request waits.
        accept(24'd1234, 24'd10);
        wait_done("bp", 24, 24'd123, 24'd4, 1'b0);
        i_in_valid = 1'b1;
        i_dividend = 24'd50;
        i_divisor  = 24'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            check_eq("bp_hold_vld", {31'd0, o_out_valid}, 32'd1);
            check_eq("bp_hold_rdy", {31'd0, o_in_ready}, 32'd0);
            check_eq("bp_hold_q", {8'd0, o_quotient}, 32'd123);
            check_eq("bp_hold_r", {8'd0, o_remainder}, 32'd4);
        end
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
        check_eq("bp_rel_vld", {31'd0, o_out_valid}, 32'd0);
        check_eq("bp_rel_rdy", {31'd0, o_in_ready}, 32'd1);
        // i_in_valid is still high, so the waiting 50/5 is accepted at this edge.
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        check_eq("bp_acc_rdy", {31'd0, o_in_ready}, 32'd0);
        wait_done("bp_next", 24, 24'd10, 24'd0, 1'b0);
        release_out("bp_next");

        // Reset during the 10th BUSY cycle of 1000/3.
        accept(24'd1000, 24'd3);
        repeat (9) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check_eq("mrst_rdy", {31'd0, o_in_ready}, 32'd1);
        check_eq("mrst_vld", {31'd0, o_out_valid}, 32'd0);
        check_eq("mrst_q", {8'd0, o_quotient}, 32'd0);
        check_eq("mrst_r", {8'd0, o_remainder}, 32'd0);
        check_eq("mrst_dbz", {31'd0, o_div_by_zero}, 32'd0);
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge i_clk); #1;
            if (o_out_valid) quiet++;
        end
        check_eq("mrst_no_vld", 32'(quiet), 32'd0);
        run_op("after_rst", 24'd1000, 24'd3, 24'd333, 24'd1);

        // Random pairs, about 10% with a zero divisor.
        for (int i = 0; i < 300; i++) begin
            ra = 24'($urandom);
            rb = ($urandom_range(9, 0) == 0) ? 24'd0 : 24'($urandom >> $urandom_range(23, 0));
            if (rb == 24'd0) begin
                rq = 24'hFFFFFF;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_op("rand", ra, rb, rq, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/div_24bit_seq.md
# div_24bit_seq

Sequential 24-bit unsigned restoring divider: the subtract-and-shift counterpart to the team's 24-bit carry-lookahead adder. It sits beside the mantissa datapath and serves FP mantissa division and integer DIV/REM requests. Each request produces a quotient and remainder after a fixed number of iterations. Valid/ready handshakes on the input and output decouple it from the pipeline, and it stalls under output backpressure.

## Interface
- WIDTH, 24, operand/result width in bits (≥2)
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_in_valid  in  1  request present
- o_in_ready  out  1  divider can accept a request (IDLE only)
- i_dividend  in  WIDTH  unsigned dividend, sampled on accept
- i_divisor  in  WIDTH  unsigned divisor, sampled on accept
- o_out_valid  out  1  result available
- i_out_ready  in  1  consumer takes result
- o_quotient  out  WIDTH  unsigned quotient
- o_remainder  out  WIDTH  unsigned remainder
- o_div_by_zero  out  1  result came from a zero divisor

## Operation
- States: IDLE, BUSY, DONE (one-hot or encoded; implementer's choice).
- IDLE: o_in_ready=1. On an edge with i_in_valid && o_in_ready (the "accept"):
  - latch the divisor;
  - load the quotient shift register with the dividend;
  - clear the (WIDTH+1)-bit partial remainder;
  - clear the iteration counter.
  - If divisor==0: go directly to DONE with quotient = all ones, remainder = dividend, o_div_by_zero=1.
  - Otherwise go to BUSY.
- BUSY, one iteration per cycle, WIDTH iterations:
  - r' = {r[WIDTH-1:0], q[WIDTH-1]}; q' = q << 1.
  - d = r' − {1'b0, divisor}, computed WIDTH+1 bits wide.
  - If d[WIDTH]==0: r = d, q'[0]=1. Else: r = r', q'[0]=0.
  - Counter increments; after the iteration with counter==WIDTH−1, go to DONE.
- DONE: o_out_valid=1; o_quotient = q, o_remainder = r[WIDTH-1:0], o_div_by_zero as latched. Results are registered and hold stable until the output handshake.
  - On an edge with o_out_valid && i_out_ready: go to IDLE.
- No overlap: o_in_ready=0 in BUSY and DONE; requests during those states are ignored, not queued.
- Invariant for every nonzero divisor: dividend == quotient·divisor + remainder, with remainder < divisor.
- Outputs o_quotient/o_remainder/o_div_by_zero may show intermediate values while not o_out_valid; consumers qualify on o_out_valid.

## Timing
- Reset (edge with i_rst=1, regardless of state): state=IDLE; q, r, divisor, counter, o_quotient, o_remainder, o_div_by_zero = 0; o_out_valid=0; o_in_ready=1 in the cycle after reset.
- Reset mid-BUSY or mid-DONE: the operation is discarded; no o_out_valid pulse follows.
- Latency, nonzero divisor: accept at edge E; BUSY for cycles E..E+WIDTH−1; o_out_valid high starting after edge E+WIDTH (24 cycles at default).
- Latency, zero divisor: o_out_valid high after edge E+1.
- Output handshake at edge F: o_out_valid=0 and o_in_ready=1 after F. The earliest next accept is at edge F+1.
- Throughput, with i_out_ready tied high: one result per WIDTH+2 cycles.
- Simultaneous i_rst and handshake: reset wins.
- i_dividend/i_divisor are don't-care except on the accept edge.

## Test plan
- Basic: 100 / 7 accepted at edge E → o_out_valid after E+24; quotient=14, remainder=2, div_by_zero=0.
- Extremes:
  - 0xFFFFFF / 1 → quotient=0xFFFFFF, remainder=0.
  - 0xFFFFFF / 0xFFFFFF → quotient=1, remainder=0.
  - 3 / 10 → quotient=0, remainder=3.
- Divide by zero: 5 / 0 → o_out_valid after E+1; quotient=0xFFFFFF, remainder=5, div_by_zero=1.
- Backpressure: hold i_out_ready=0 for 5 cycles after o_out_valid → outputs stable, o_in_ready=0. A request offered meanwhile (50/5) is not accepted. Release → IDLE next cycle; 50/5 is then accepted and yields 10 r0.
- Reset mid-operation: assert i_rst for one cycle at the 10th BUSY cycle of 1000/3 → all outputs 0, o_in_ready=1 next cycle, no o_out_valid. Then 1000/3 → 333 r1 after 24 cycles.
- Random: 10k random operand pairs, including 10% zero divisors, against a reference model → invariant holds; each latency is exactly 24 cycles (1 for zero divisor).
